// File: rtl/bram_sdp_be.sv
// -----------------------------------------------------------------------------
// bram_sdp_be
//
// Simple-dual-port block RAM with per-byte write enables, a 1- or 2-cycle read
// pipeline with a read-valid strobe, defined same-address read-during-write
// behaviour, and a clear sequencer that fills every word with INIT_VALUE after
// reset so contents are deterministic before any user write is accepted.
//
// Parameters
//   DATA_WIDTH  word width in bits (multiple of 8)
//   ADDR_WIDTH  address width, DEPTH = 2**ADDR_WIDTH
//   RD_LATENCY  1 = data one edge after the read is sampled, 2 = extra stage
//   WRITE_FIRST 0 = colliding read sees old word, 1 = sees merged word
//   INIT_VALUE  value written to every word by the clear sequence
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   init_done  out  high once the clear sequence has finished
//   wr_ready   out  same as init_done; writes accepted only when high
//   we         in   write enable
//   wr_be      in   byte enables, bit b covers wr_data[8b+7:8b]
//   wr_addr    in   write address
//   wr_data    in   write data
//   rd_en      in   read request
//   rd_addr    in   read address
//   rd_data    out  read data, valid while rd_valid is high, held otherwise
//   rd_valid   out  one-cycle strobe per accepted read
//
// State table
//   ST_CLEAR | sweeping cnt_q over every address writing INIT_VALUE;
//            | user reads and writes are ignored
//   ST_READY | normal operation until the next reset
// -----------------------------------------------------------------------------
module bram_sdp_be #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter int unsigned           RD_LATENCY  = 1,
  parameter bit                    WRITE_FIRST = 1'b0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      init_done,
  output logic                      wr_ready,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    init_done_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    clr_fire;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    collide;
  logic [DATA_WIDTH-1:0]   merged_d;
  logic [DATA_WIDTH-1:0]   rd_word_d;

  logic                    s1_valid_q;
  logic [DATA_WIDTH-1:0]   s1_data_q;

  // ---------------------------------------------------------------------------
  // Sequencer: one address cleared per edge, READY after the last address.
  // init_done is registered alongside the state so it rises on the same edge
  // that writes LAST_ADDR.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end
        end
        ST_READY: begin
          state_q     <= ST_READY;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_CLEAR;
          cnt_q       <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign init_done = init_done_q;
  assign wr_ready  = init_done_q;

  // ---------------------------------------------------------------------------
  // Port qualification. Nothing from the user side lands while clearing.
  // ---------------------------------------------------------------------------
  assign clr_fire = rst_n && (state_q == ST_CLEAR);
  assign wr_fire  = rst_n && (state_q == ST_READY) && we;
  assign rd_fire  = (state_q == ST_READY) && rd_en;
  assign collide  = wr_fire && (wr_addr == rd_addr);

  // Word as it will look after this edge's byte-masked write; only needed for
  // the write-first collision bypass.
  always_comb begin
    merged_d = mem[wr_addr];
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (wr_be[b]) begin
        merged_d[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word_d = mem[rd_addr];
    if (WRITE_FIRST && collide) begin
      rd_word_d = merged_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Contents are never reset; the clear sweep rewrites every word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_fire) begin
      mem[cnt_q] <= INIT_VALUE;
    end else if (wr_fire) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Data registers load only on a valid beat so the output
  // holds its last value between strobes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_fire;
      if (rd_fire) begin
        s1_data_q <= rd_word_d;
      end
    end
  end

  // Any RD_LATENCY other than 1 takes the two-stage path.
  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign rd_valid = s1_valid_q;
      assign rd_data  = s1_data_q;
    end else begin : g_lat2
      logic                  s2_valid_q;
      logic [DATA_WIDTH-1:0] s2_data_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            s2_data_q <= s1_data_q;
          end
        end
      end

      assign rd_valid = s2_valid_q;
      assign rd_data  = s2_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_bram_sdp_be.sv
// Three instances share one stimulus stream:
//   0: RD_LATENCY=1, WRITE_FIRST=0
//   1: RD_LATENCY=1, WRITE_FIRST=1
//   2: RD_LATENCY=2, WRITE_FIRST=0
// Stimulus pushes the expected read word per instance; a negedge monitor pops
// on every rd_valid and also checks that rd_data holds between strobes.
module tb_bram_sdp_be;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          we;
  logic [3:0]    wr_be;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic          id [3];
  logic          wrdy [3];
  logic          mv [3];
  logic [DW-1:0] md [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bram_sdp_be #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RD_LATENCY ((g == 2) ? 2 : 1),
      .WRITE_FIRST(g == 1),
      .INIT_VALUE ('0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .init_done(id[g]),
      .wr_ready (wrdy[g]),
      .we       (we),
      .wr_be    (wr_be),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (md[g]),
      .rd_valid (mv[g])
    );
  end

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] sbq [3][$];
  logic [DW-1:0] last_q [3];
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [DW-1:0] e;
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (mv[i] === 1'b1) begin
          if (sbq[i].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid[%0d]: got rd_valid=1 data %08h, expected no pending read", i, md[i]);
          end else begin
            e = sbq[i].pop_front();
            check($sformatf("rd_data[%0d]", i), md[i], e);
            last_q[i] = e;
          end
        end else begin
          check($sformatf("rd_hold[%0d]", i), md[i], last_q[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we    = 1'b0;
    rd_en = 1'b0;
    wr_be = 4'h0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] be);
    we      = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    wr_be   = be;
    tick();
    we      = 1'b0;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    sbq[0].push_back(e0);
    sbq[1].push_back(e1);
    sbq[2].push_back(e2);
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic wr_rd(input int wa, input logic [DW-1:0] d, input logic [3:0] be, input int ra,
                       input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    we      = 1'b1;
    wr_addr = AW'(wa);
    wr_data = d;
    wr_be   = be;
    rd(ra, e0, e1, e2);
    we      = 1'b0;
  endtask

  initial begin
    int w;
    rst_n   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    idle();
    for (int i = 0; i < 3; i++) last_q[i] = '0;

    // Init: three reset edges, then user traffic during the sweep is ignored.
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_valid[%0d]", i), mv[i], 0);
      check($sformatf("reset_data[%0d]", i), md[i], 0);
      check($sformatf("reset_init_done[%0d]", i), id[i], 0);
    end
    mon_en  = 1'b1;
    rst_n   = 1'b1;
    we      = 1'b1;
    wr_addr = AW'(5);
    wr_data = 32'hFFFF_FFFF;
    wr_be   = 4'hF;
    rd_en   = 1'b1;
    rd_addr = AW'(5);
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (k == DEPTH - 1) begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("init_done_edge1023[%0d]", i), id[i], 0);
          check($sformatf("wr_ready_edge1023[%0d]", i), wrdy[i], 0);
        end
        idle();
      end
      if (k == DEPTH) begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("init_done_edge1024[%0d]", i), id[i], 1);
          check($sformatf("wr_ready_edge1024[%0d]", i), wrdy[i], 1);
        end
      end
    end
    for (int a = 0; a < DEPTH; a++) rd(a, 32'h0, 32'h0, 32'h0);
    repeat (3) tick();

    // Full sweep, back-to-back reads.
    for (int a = 0; a < DEPTH; a++) wr(a, DW'(a), 4'hF);
    for (int a = 0; a < DEPTH; a++) rd(a, DW'(a), DW'(a), DW'(a));
    repeat (3) tick();

    // Byte enables, including the all-zero mask.
    wr(5, 32'hAABB_CCDD, 4'hF);
    wr(5, 32'h1122_3344, 4'b0101);
    rd(5, 32'hAA22_CC44, 32'hAA22_CC44, 32'hAA22_CC44);
    wr(9, 32'hFFFF_FFFF, 4'b0000);
    rd(9, 32'h9, 32'h9, 32'h9);

    // Collision and non-colliding simultaneous access.
    wr(7, 32'h1234_5678, 4'hF);
    wr_rd(7, 32'hFFFF_FFFF, 4'b0011, 7, 32'h1234_5678, 32'h1234_FFFF, 32'h1234_5678);
    rd(7, 32'h1234_FFFF, 32'h1234_FFFF, 32'h1234_FFFF);
    wr_rd(8, 32'hCAFE_0008, 4'hF, 9, 32'h9, 32'h9, 32'h9);
    rd(8, 32'hCAFE_0008, 32'hCAFE_0008, 32'hCAFE_0008);
    repeat (3) tick();

    // Latency: read 3 then 4 back-to-back, observe strobe timing.
    wr(3, 32'hDEAD_BEEF, 4'hF);
    rd_en   = 1'b1;
    rd_addr = AW'(3);
    for (int i = 0; i < 3; i++) sbq[i].push_back(32'hDEAD_BEEF);
    tick();
    check("lat1_valid_first_edge", mv[0], 1);
    check("lat2_valid_first_edge", mv[2], 0);
    rd_addr = AW'(4);
    for (int i = 0; i < 3; i++) sbq[i].push_back(32'h4);
    tick();
    rd_en = 1'b0;
    check("lat2_valid_second_edge", mv[2], 1);
    check("lat2_data_second_edge", md[2], 32'hDEAD_BEEF);
    tick();
    check("lat2_valid_third_edge", mv[2], 1);
    check("lat1_valid_third_edge", mv[0], 0);
    tick();
    check("lat2_valid_fourth_edge", mv[2], 0);
    repeat (2) tick();

    // Reset mid-stream; pending results are dropped.
    for (int a = 10; a < 20; a++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      for (int i = 0; i < 3; i++) sbq[i].push_back(DW'(a));
      tick();
    end
    rst_n   = 1'b0;
    rd_addr = AW'(20);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sbq[i].delete();
      last_q[i] = '0;
      check($sformatf("midreset_valid[%0d]", i), mv[i], 0);
      check($sformatf("midreset_init_done[%0d]", i), id[i], 0);
    end
    we      = 1'b1;
    wr_addr = AW'(5);
    wr_data = 32'hFFFF_FFFF;
    wr_be   = 4'hF;
    w = 0;
    while (!(id[0] && id[1] && id[2]) && w < DEPTH + 50) begin
      tick();
      w++;
    end
    idle();
    for (int i = 0; i < 3; i++) check($sformatf("reinit_done[%0d]", i), id[i], 1);
    check("reinit_edges", w, DEPTH);
    rd(5, 32'h0, 32'h0, 32'h0);
    rd(7, 32'h0, 32'h0, 32'h0);
    repeat (4) tick();

    for (int i = 0; i < 3; i++) check($sformatf("sb_drained[%0d]", i), sbq[i].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
